// File: rtl/dma_ctrl.sv
// Memory-to-memory DMA controller (copy / fill) for the shared RAM bus, CPU-programmed via an IO bank.
// Optional feature macro: DMA_FILL_EN enables fill mode and the FILL register.
module dma_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cs_i,
  input  logic        R_W_n,
  input  logic [3:0]  addr_i,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  output logic        rdy_o,
  output logic        bus_req_o,
  output logic [15:0] dma_addr_o,
  output logic [7:0]  dma_data_o,
  output logic        dma_we_o,
  input  logic [7:0]  dma_data_i,
  output logic        irq_o
);

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  state_t state_q, state_d;

  logic [15:0]      src_reg, dst_reg, len_reg;
  logic             irq_en, done, busy;
  logic             fill_mode;
  logic [7:0]       fill_val;
  logic [15:0]      src_ptr, dst_ptr;
  logic [LEN_W-1:0] count;
  logic [7:0]       buffer;

  logic reg_wr, status_rd, start, start_fill, len_zero, last_wr;

  assign reg_wr     = cs_i & ~R_W_n & ~busy;
  assign status_rd  = cs_i & R_W_n & (addr_i == 4'd7);
  assign start      = reg_wr & (addr_i == 4'd6) & data_i[0];
  assign len_zero   = (len_reg[LEN_W-1:0] == '0);
  assign last_wr    = (state_q == WR) && (count == LEN_W'(1));

`ifdef DMA_FILL_EN
  logic [7:0] fill_reg;

  // Fill byte and mode bit only exist when fill support is built in
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fill_reg  <= 8'h00;
      fill_mode <= 1'b0;
    end else if (reg_wr) begin
      if (addr_i == 4'd8) fill_reg <= data_i;
      if (addr_i == 4'd6) fill_mode <= data_i[1];
    end
  end

  assign fill_val   = fill_reg;
  assign start_fill = data_i[1];
`else
  assign fill_mode  = 1'b0;
  assign fill_val   = 8'h00;
  assign start_fill = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_reg <= 16'h0000;
      dst_reg <= 16'h0000;
      len_reg <= 16'h0000;
      irq_en  <= 1'b0;
    end else if (reg_wr) begin
      case (addr_i)
        4'd0: src_reg[7:0]  <= data_i;
        4'd1: src_reg[15:8] <= data_i;
        4'd2: dst_reg[7:0]  <= data_i;
        4'd3: dst_reg[15:8] <= data_i;
        4'd4: len_reg[7:0]  <= data_i;
        4'd5: len_reg[15:8] <= data_i;
        4'd6: irq_en        <= data_i[2];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && !len_zero) state_d = start_fill ? WR : RD;
      RD:   state_d = CAP;
      CAP:  state_d = WR;
      WR: begin
        if (count == LEN_W'(1)) state_d = IDLE;
        else                    state_d = fill_mode ? WR : RD;
      end
      default: state_d = IDLE;
    endcase
  end

  // busy is registered so rdy_o/bus_req_o come straight from a flop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_ptr <= 16'h0000;
      dst_ptr <= 16'h0000;
      count   <= '0;
      buffer  <= 8'h00;
    end else begin
      if (state_q == IDLE && start) begin
        src_ptr <= src_reg;
        dst_ptr <= dst_reg;
        count   <= len_reg[LEN_W-1:0];
      end
      if (state_q == CAP) begin
        buffer  <= dma_data_i;
        src_ptr <= src_ptr + 16'h0001;
      end
      if (state_q == WR) begin
        dst_ptr <= dst_ptr + 16'h0001;
        count   <= count - LEN_W'(1);
      end
    end
  end

  // Completion set has priority over the read-to-clear of STATUS
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                             done <= 1'b0;
    else if (last_wr || (state_q == IDLE && start && len_zero)) done <= 1'b1;
    else if (status_rd)                                    done <= 1'b0;
  end

  always_comb begin
    dma_addr_o = 16'h0000;
    dma_data_o = 8'h00;
    dma_we_o   = 1'b0;
    case (state_q)
      RD, CAP: dma_addr_o = src_ptr;
      WR: begin
        dma_addr_o = dst_ptr;
        dma_we_o   = 1'b1;
        dma_data_o = fill_mode ? fill_val : buffer;
      end
      default: ;
    endcase
  end

  always_comb begin
    data_o = 8'h00;
    case (addr_i)
      4'd0: data_o = src_reg[7:0];
      4'd1: data_o = src_reg[15:8];
      4'd2: data_o = dst_reg[7:0];
      4'd3: data_o = dst_reg[15:8];
      4'd4: data_o = len_reg[7:0];
      4'd5: data_o = len_reg[15:8];
      4'd6: data_o = {5'b00000, irq_en, fill_mode, 1'b0};
      4'd7: data_o = {6'b000000, done, busy};
      4'd8: data_o = fill_val;
      default: data_o = 8'h00;
    endcase
  end

  assign rdy_o     = ~busy;
  assign bus_req_o = busy;
  assign irq_o     = done & irq_en;

endmodule

// File: tb/tb_dma_ctrl.sv
// Self-checking bench for dma_ctrl: RAM model, bus monitor and a byte-level reference of memory contents.
// Fill checks follow the DMA_FILL_EN build option.
module tb_dma_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cs_i, R_W_n;
  logic [3:0]  addr_i;
  logic [7:0]  data_i, data_o;
  logic        rdy_o, bus_req_o, dma_we_o, irq_o;
  logic [15:0] dma_addr_o;
  logic [7:0]  dma_data_o;
  logic [7:0]  dma_data_i;

  int checks = 0;
  int errors = 0;

  dma_ctrl #(.LEN_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cs_i(cs_i), .R_W_n(R_W_n), .addr_i(addr_i),
    .data_i(data_i), .data_o(data_o), .rdy_o(rdy_o), .bus_req_o(bus_req_o),
    .dma_addr_o(dma_addr_o), .dma_data_o(dma_data_o), .dma_we_o(dma_we_o),
    .dma_data_i(dma_data_i), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  // RAM with one-cycle read latency; bd_* is the bench's preload port
  logic [7:0]  mem [0:65535];
  logic [7:0]  shadow [0:65535];
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = 16'h0000;
  logic [7:0]  bd_data = 8'h00;

  always @(posedge clk_i) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (dma_we_o) mem[dma_addr_o] <= dma_data_o;
    dma_data_i <= mem[dma_addr_o];
  end

  // Bus monitor: stall cycles, write strobes, distinct read/write addresses
  int          we_cnt = 0;
  int          low_cnt = 0;
  logic [15:0] rd_q[$];
  logic [15:0] wr_q[$];
  bit          last_rd = 1'b0;
  logic [15:0] last_a = 16'h0000;

  always @(negedge clk_i) begin
    if (rdy_o === 1'b0) low_cnt++;
    if (dma_we_o === 1'b1) begin
      we_cnt++;
      wr_q.push_back(dma_addr_o);
      last_rd = 1'b0;
    end else if (bus_req_o === 1'b1) begin
      if (!(last_rd && last_a == dma_addr_o)) rd_q.push_back(dma_addr_o);
      last_rd = 1'b1;
      last_a  = dma_addr_o;
    end else begin
      last_rd = 1'b0;
    end
  end

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk_i);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    shadow[a] = d;
    @(posedge clk_i); #1;
    bd_we = 1'b0;
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk_i);
    cs_i = 1'b1; R_W_n = 1'b0; addr_i = a; data_i = d;
    @(posedge clk_i); #1;
    cs_i = 1'b0; R_W_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk_i);
    cs_i = 1'b1; R_W_n = 1'b1; addr_i = a;
    #1 d = data_o;
    @(posedge clk_i); #1;
    cs_i = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < maxc; n++) begin
      @(negedge clk_i);
      if (rdy_o === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic program_and_run(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                                 input logic [7:0] ctrl, output bit ok);
    cpu_write(4'd0, s[7:0]);  cpu_write(4'd1, s[15:8]);
    cpu_write(4'd2, d[7:0]);  cpu_write(4'd3, d[15:8]);
    cpu_write(4'd4, l[7:0]);  cpu_write(4'd5, l[15:8]);
    cpu_write(4'd6, ctrl);
    wait_idle(1000, ok);
  endtask

  // Reference: sequential byte copy with 16-bit address wrap
  task automatic ref_copy(input logic [15:0] s, input logic [15:0] d, input int l);
    for (int i = 0; i < l; i++) shadow[16'(d + i)] = shadow[16'(s + i)];
  endtask

  task automatic test_reset();
    logic [7:0] v;
    checks++; if (rdy_o !== 1'b1)        begin errors++; $display("[TB] FAIL reset_rdy: got %b expected 1", rdy_o); end
    checks++; if (bus_req_o !== 1'b0)    begin errors++; $display("[TB] FAIL reset_bus_req: got %b expected 0", bus_req_o); end
    checks++; if (dma_we_o !== 1'b0)     begin errors++; $display("[TB] FAIL reset_we: got %b expected 0", dma_we_o); end
    checks++; if (dma_addr_o !== 16'h0)  begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0000", dma_addr_o); end
    checks++; if (dma_data_o !== 8'h0)   begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 00", dma_data_o); end
    checks++; if (irq_o !== 1'b0)        begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", irq_o); end
    for (int r = 0; r < 16; r++) begin
      cpu_read(4'(r), v);
      checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL reset_reg%0d: got %h expected 00", r, v); end
    end
  endtask

  task automatic test_copy();
    logic [7:0] v;
    logic [7:0] exp_b [4];
    int wb, lb;
    bit ok;
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) preload(16'h0200 + 16'(i), exp_b[i]);
    for (int i = 0; i < 5; i++) preload(16'h0300 + 16'(i), 8'($urandom));
    wb = we_cnt; lb = low_cnt;
    program_and_run(16'h0200, 16'h0300, 16'd4, 8'h01, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL copy_timeout: rdy_o never returned high"); end
    checks++; if (low_cnt - lb != 12) begin errors++; $display("[TB] FAIL copy_rdy_low: got %0d cycles expected 12", low_cnt - lb); end
    checks++; if (we_cnt - wb != 4) begin errors++; $display("[TB] FAIL copy_we: got %0d strobes expected 4", we_cnt - wb); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16'h0300 + 16'(i)] !== exp_b[i]) begin
        errors++; $display("[TB] FAIL copy_byte%0d: got %h expected %h", i, mem[16'h0300 + 16'(i)], exp_b[i]);
      end
    end
    checks++; if (mem[16'h0304] !== shadow[16'h0304]) begin errors++; $display("[TB] FAIL copy_guard: got %h expected %h", mem[16'h0304], shadow[16'h0304]); end
    cpu_read(4'd7, v);
    checks++; if (v !== 8'h02) begin errors++; $display("[TB] FAIL copy_status1: got %h expected 02", v); end
    cpu_read(4'd7, v);
    checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL copy_status2: got %h expected 00", v); end
  endtask

  task automatic test_fill();
    logic [7:0] v;
    int wb, lb;
    bit ok;
    for (int i = 0; i < 4; i++) preload(16'h0400 + 16'(i), 8'($urandom));
    for (int i = 0; i < 3; i++) preload(16'h0500 + 16'(i), 8'($urandom));
    cpu_write(4'd8, 8'hAA);
    wb = we_cnt; lb = low_cnt;
    program_and_run(16'h0500, 16'h0400, 16'd3, 8'h03, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL fill_timeout: rdy_o never returned high"); end
    checks++; if (we_cnt - wb != 3) begin errors++; $display("[TB] FAIL fill_we: got %0d strobes expected 3", we_cnt - wb); end
`ifdef DMA_FILL_EN
    for (int i = 0; i < 3; i++) shadow[16'h0400 + 16'(i)] = 8'hAA;
    checks++; if (low_cnt - lb != 3) begin errors++; $display("[TB] FAIL fill_rdy_low: got %0d cycles expected 3", low_cnt - lb); end
    cpu_read(4'd8, v);
    checks++; if (v !== 8'hAA) begin errors++; $display("[TB] FAIL fill_reg: got %h expected AA", v); end
    cpu_read(4'd6, v);
    checks++; if (v !== 8'h02) begin errors++; $display("[TB] FAIL fill_ctrl: got %h expected 02", v); end
`else
    ref_copy(16'h0500, 16'h0400, 3);
    checks++; if (low_cnt - lb != 9) begin errors++; $display("[TB] FAIL nofill_rdy_low: got %0d cycles expected 9", low_cnt - lb); end
    cpu_read(4'd8, v);
    checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL nofill_reg: got %h expected 00", v); end
    cpu_read(4'd6, v);
    checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL nofill_ctrl: got %h expected 00", v); end
`endif
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16'h0400 + 16'(i)] !== shadow[16'h0400 + 16'(i)]) begin
        errors++; $display("[TB] FAIL fill_byte%0d: got %h expected %h", i, mem[16'h0400 + 16'(i)], shadow[16'h0400 + 16'(i)]);
      end
    end
    cpu_read(4'd7, v);
  endtask

  task automatic test_wrap();
    logic [15:0] exp_rd [3];
    logic [15:0] exp_wr [3];
    logic [7:0] v;
    int rb, wb;
    bit ok;
    exp_rd = '{16'hFFFE, 16'hFFFF, 16'h0000};
    exp_wr = '{16'hFFFF, 16'h0000, 16'h0001};
    preload(16'hFFFE, 8'($urandom)); preload(16'hFFFF, 8'($urandom));
    preload(16'h0000, 8'($urandom)); preload(16'h0001, 8'($urandom)); preload(16'h0002, 8'($urandom));
    ref_copy(16'hFFFE, 16'hFFFF, 3);
    rb = rd_q.size(); wb = wr_q.size();
    program_and_run(16'hFFFE, 16'hFFFF, 16'd3, 8'h01, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL wrap_timeout: rdy_o never returned high"); end
    checks++; if (rd_q.size() - rb != 3 || wr_q.size() - wb != 3) begin
      errors++; $display("[TB] FAIL wrap_count: got %0d reads %0d writes expected 3 and 3", rd_q.size() - rb, wr_q.size() - wb);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (rd_q[rb + i] !== exp_rd[i]) begin errors++; $display("[TB] FAIL wrap_rd%0d: got %h expected %h", i, rd_q[rb + i], exp_rd[i]); end
        checks++; if (wr_q[wb + i] !== exp_wr[i]) begin errors++; $display("[TB] FAIL wrap_wr%0d: got %h expected %h", i, wr_q[wb + i], exp_wr[i]); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16'(16'hFFFF + i)] !== shadow[16'(16'hFFFF + i)]) begin
        errors++; $display("[TB] FAIL wrap_byte%0d: got %h expected %h", i, mem[16'(16'hFFFF + i)], shadow[16'(16'hFFFF + i)]);
      end
    end
    cpu_read(4'd7, v);
  endtask

  task automatic test_random_copy();
    logic [15:0] s, d;
    logic [7:0] v;
    int l, wb, lb;
    bit ok;
    for (int it = 0; it < 4; it++) begin
      s = 16'($urandom);
      d = s + 16'h1000 + 16'($urandom_range(0, 16'h7000));
      l = $urandom_range(1, 20);
      for (int i = 0; i < l; i++) preload(16'(s + i), 8'($urandom));
      for (int i = 0; i <= l; i++) preload(16'(d + i), 8'($urandom));
      ref_copy(s, d, l);
      wb = we_cnt; lb = low_cnt;
      program_and_run(s, d, 16'(l), 8'h01, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL rand%0d_timeout: rdy_o never returned high", it); end
      checks++; if (low_cnt - lb != 3 * l) begin errors++; $display("[TB] FAIL rand%0d_rdy_low: got %0d expected %0d", it, low_cnt - lb, 3 * l); end
      checks++; if (we_cnt - wb != l) begin errors++; $display("[TB] FAIL rand%0d_we: got %0d expected %0d", it, we_cnt - wb, l); end
      for (int i = 0; i <= l; i++) begin
        checks++;
        if (mem[16'(d + i)] !== shadow[16'(d + i)]) begin
          errors++; $display("[TB] FAIL rand%0d_byte%0d: got %h expected %h", it, i, mem[16'(d + i)], shadow[16'(d + i)]);
        end
      end
      cpu_read(4'd7, v);
      checks++; if (v !== 8'h02) begin errors++; $display("[TB] FAIL rand%0d_status: got %h expected 02", it, v); end
    end
  endtask

  task automatic test_lockout();
    logic [7:0] v;
    int wb;
    bit ok;
    for (int i = 0; i < 5; i++) preload(16'h0600 + 16'(i), 8'($urandom));
    for (int i = 0; i < 6; i++) preload(16'h0700 + 16'(i), 8'($urandom));
    ref_copy(16'h0600, 16'h0700, 5);
    wb = wr_q.size();
    cpu_write(4'd0, 8'h00); cpu_write(4'd1, 8'h06);
    cpu_write(4'd2, 8'h00); cpu_write(4'd3, 8'h07);
    cpu_write(4'd4, 8'h05); cpu_write(4'd5, 8'h00);
    cpu_write(4'd6, 8'h01);
    cpu_write(4'd0, 8'h55);
    cpu_write(4'd4, 8'h01);
    cpu_read(4'd0, v);
    checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL lock_src_busy: got %h expected 00", v); end
    cpu_read(4'd7, v);
    checks++; if (v !== 8'h01) begin errors++; $display("[TB] FAIL lock_status_busy: got %h expected 01", v); end
    wait_idle(1000, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL lock_timeout: rdy_o never returned high"); end
    checks++; if (wr_q.size() - wb != 5) begin
      errors++; $display("[TB] FAIL lock_wr_count: got %0d expected 5", wr_q.size() - wb);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (wr_q[wb + i] !== 16'h0700 + 16'(i)) begin errors++; $display("[TB] FAIL lock_wr%0d: got %h expected %h", i, wr_q[wb + i], 16'h0700 + 16'(i)); end
      end
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (mem[16'h0700 + 16'(i)] !== shadow[16'h0700 + 16'(i)]) begin
        errors++; $display("[TB] FAIL lock_byte%0d: got %h expected %h", i, mem[16'h0700 + 16'(i)], shadow[16'h0700 + 16'(i)]);
      end
    end
    cpu_read(4'd4, v);
    checks++; if (v !== 8'h05) begin errors++; $display("[TB] FAIL lock_len: got %h expected 05", v); end
    cpu_read(4'd7, v);
  endtask

  task automatic test_zero_len();
    logic [7:0] v;
    int wb, lb;
    cpu_write(4'd4, 8'h00); cpu_write(4'd5, 8'h00);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL zero_irq_before: got %b expected 0", irq_o); end
    wb = we_cnt; lb = low_cnt;
    cpu_write(4'd6, 8'h05);
    @(posedge clk_i); #1;
    checks++; if (irq_o !== 1'b1) begin errors++; $display("[TB] FAIL zero_irq: got %b expected 1", irq_o); end
    repeat (3) @(negedge clk_i);
    checks++; if (we_cnt != wb) begin errors++; $display("[TB] FAIL zero_we: got %0d strobes expected 0", we_cnt - wb); end
    checks++; if (low_cnt != lb) begin errors++; $display("[TB] FAIL zero_rdy_low: got %0d cycles expected 0", low_cnt - lb); end
    cpu_read(4'd7, v);
    checks++; if (v !== 8'h02) begin errors++; $display("[TB] FAIL zero_status: got %h expected 02", v); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL zero_irq_clear: got %b expected 0", irq_o); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    int wb;
    cpu_write(4'd0, 8'h00); cpu_write(4'd1, 8'h08);
    cpu_write(4'd2, 8'h00); cpu_write(4'd3, 8'h09);
    cpu_write(4'd4, 8'd100); cpu_write(4'd5, 8'h00);
    cpu_write(4'd6, 8'h05);
    repeat (10) @(negedge clk_i);
    checks++; if (bus_req_o !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 1", bus_req_o); end
    rst_i = 1'b1;
    #1;
    checks++; if (rdy_o !== 1'b1)       begin errors++; $display("[TB] FAIL mid_rdy: got %b expected 1", rdy_o); end
    checks++; if (bus_req_o !== 1'b0)   begin errors++; $display("[TB] FAIL mid_bus_req: got %b expected 0", bus_req_o); end
    checks++; if (dma_we_o !== 1'b0)    begin errors++; $display("[TB] FAIL mid_we: got %b expected 0", dma_we_o); end
    checks++; if (dma_addr_o !== 16'h0) begin errors++; $display("[TB] FAIL mid_addr: got %h expected 0000", dma_addr_o); end
    checks++; if (irq_o !== 1'b0)       begin errors++; $display("[TB] FAIL mid_irq: got %b expected 0", irq_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    wb = we_cnt;
    repeat (30) @(negedge clk_i);
    checks++; if (we_cnt != wb) begin errors++; $display("[TB] FAIL mid_we_after: got %0d strobes expected 0", we_cnt - wb); end
    cpu_read(4'd7, v);
    checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL mid_status: got %h expected 00", v); end
    cpu_read(4'd1, v);
    checks++; if (v !== 8'h00) begin errors++; $display("[TB] FAIL mid_src_h: got %h expected 00", v); end
  endtask

  initial begin
    rst_i = 1'b1; cs_i = 1'b0; R_W_n = 1'b1; addr_i = 4'd0; data_i = 8'h00;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    test_reset();
    test_copy();
    test_fill();
    test_wrap();
    test_random_copy();
    test_lockout();
    test_zero_len();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
